// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with 2-credit request window, in-order PC tagging,
// a 2-entry response FIFO behind the IF/ID register, and redirect flush with stale-response drop.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req_valid,
    output logic [31:0] im_req_addr,
    input  logic        im_req_ready,
    input  logic        im_rsp_valid,
    input  logic [31:0] im_rsp_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);
    logic [31:0] pc, id_inst_q;
    logic [1:0]  inflight, drop_cnt, fifo_count, tag_count, inflight_nxt;
    logic [31:0] tag_q [2];
    logic [31:0] fpc_q [2];
    logic [31:0] finst_q [2];
    logic        started, acc, rsp_live, load, bypass, fifo_pop, fifo_push, fifo_wr, tag_wr;
    always_comb begin
        im_req_addr  = pc;
        im_req_valid = started && !redirect_valid && ({1'b0, inflight} + {1'b0, fifo_count} < 3'd2);
        acc          = im_req_valid && im_req_ready;
        rsp_live     = im_rsp_valid && drop_cnt == 2'd0;
        load         = !id_valid || !id_stall;
        fifo_pop     = load && fifo_count != 2'd0;
        bypass       = load && fifo_count == 2'd0 && rsp_live;
        fifo_push    = rsp_live && !bypass;
        fifo_wr      = fifo_count[0] ^ fifo_pop;
        tag_wr       = tag_count[0] ^ rsp_live;
        inflight_nxt = inflight + {1'b0, acc} - {1'b0, im_rsp_valid};
        id_inst      = id_valid ? id_inst_q : NOP_INST;
    end
    // started holds off requests until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            started    <= 1'b0;
            inflight   <= 2'd0;
            drop_cnt   <= 2'd0;
            fifo_count <= 2'd0;
            tag_count  <= 2'd0;
            id_valid   <= 1'b0;
            id_pc      <= 32'd0;
            id_inst_q  <= NOP_INST;
            tag_q[0]   <= 32'd0;
            tag_q[1]   <= 32'd0;
            fpc_q[0]   <= 32'd0;
            fpc_q[1]   <= 32'd0;
            finst_q[0] <= 32'd0;
            finst_q[1] <= 32'd0;
        end else begin
            started  <= 1'b1;
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                pc         <= redirect_pc & ~32'd3;
                fifo_count <= 2'd0;
                tag_count  <= 2'd0;
                id_valid   <= 1'b0;
                drop_cnt   <= inflight_nxt;
            end else begin
                if (acc) pc <= pc + 32'd4;
                if (im_rsp_valid && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
                if (rsp_live) tag_q[0] <= tag_q[1];
                if (acc) tag_q[tag_wr] <= pc;
                tag_count <= tag_count + {1'b0, acc} - {1'b0, rsp_live};
                if (fifo_pop) begin
                    fpc_q[0]   <= fpc_q[1];
                    finst_q[0] <= finst_q[1];
                end
                if (fifo_push) begin
                    fpc_q[fifo_wr]   <= tag_q[0];
                    finst_q[fifo_wr] <= im_rsp_inst;
                end
                fifo_count <= fifo_count - {1'b0, fifo_pop} + {1'b0, fifo_push};
                if (load) begin
                    id_valid <= fifo_pop || bypass;
                    if (fifo_pop) begin
                        id_pc     <= fpc_q[0];
                        id_inst_q <= finst_q[0];
                    end else if (bypass) begin
                        id_pc     <= tag_q[0];
                        id_inst_q <= im_rsp_inst;
                    end
                end
            end
        end
    end
endmodule
